// File: rtl/shifter_pkg.sv
// Shared definitions for the universal shifter: mode codes, FSM state encoding
// and a mode validity check.
package shifter_pkg;

    localparam logic [2:0] MODE_LSL = 3'd0;
    localparam logic [2:0] MODE_LSR = 3'd1;
    localparam logic [2:0] MODE_ASR = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Codes 5..7 are reserved; start with one of these is silently dropped.
    function automatic logic mode_valid(input logic [2:0] m);
        return (m <= MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One single-bit shift/rotate step: next register value and the bit that leaves.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       mode_i,
    input  logic             serial_in_i,
    output logic [WIDTH-1:0] q_o,
    output logic             out_o
);

    always_comb begin
        q_o   = q_i;
        out_o = 1'b0;
        case (mode_i)
            MODE_LSL: begin
                q_o   = {q_i[WIDTH-2:0], serial_in_i};
                out_o = q_i[WIDTH-1];
            end
            MODE_LSR: begin
                q_o   = {serial_in_i, q_i[WIDTH-1:1]};
                out_o = q_i[0];
            end
            MODE_ASR: begin
                q_o   = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
                out_o = q_i[0];
            end
            MODE_ROL: begin
                q_o   = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                out_o = q_i[WIDTH-1];
            end
            MODE_ROR: begin
                q_o   = {q_i[0], q_i[WIDTH-1:1]};
                out_o = q_i[0];
            end
            default: begin
                q_o   = q_i;
                out_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shifter.sv
// Parallel-load shift register executing a multi-cycle shift/rotate command
// with a start/busy/done handshake.
module universal_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    state_t             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [2:0]         mode_q;
    logic [AMT_W-1:0]   count_q;
    logic               sout_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   step_q;
    logic               step_out;

    // The step always sees the latched mode, so input changes mid-command are inert.
    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q_i         (shreg_q),
        .mode_i      (mode_q),
        .serial_in_i (serial_in),
        .q_o         (step_q),
        .out_o       (step_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            mode_q  <= MODE_LSL;
            count_q <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        shreg_q <= load_val;
                    end else if (start && mode_valid(mode)) begin
                        mode_q <= mode;
                        if (amount == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            count_q <= amount;
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    shreg_q <= step_q;
                    sout_q  <= step_out;
                    count_q <= count_q - AMT_W'(1);
                    if (count_q == AMT_W'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q          = shreg_q;
    assign serial_out = sout_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/universal_shifter.md
# universal_shifter

Parametrised, multi-mode shift register for the board-level datapath: replaces the fixed 8-bit, single-direction, one-bit-per-press shifter with a WIDTH-bit register that loads in parallel and executes a multi-cycle shift or rotate of a programmable amount. Supported modes are logical left/right, arithmetic right, and rotate left/right. A start/busy/done handshake lets a controller FSM, or a debounced KEY, issue one command and wait for completion.

## Interface
- WIDTH, 8: register width in bits (≥2).
- AMT_W, 4: width of the shift-amount field.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  parallel-load request (level sampled at clk edge).
- load_val  in  WIDTH  parallel-load data.
- start  in  1  begin a shift command.
- mode  in  3  0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR; 5–7 reserved.
- amount  in  AMT_W  number of single-bit steps to perform.
- serial_in  in  1  fill bit for LSL/LSR.
- q  out  WIDTH  register contents.
- serial_out  out  1  last bit shifted or rotated out.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- Reset values: state IDLE, q=0, serial_out=0, busy=0, done=0, counter=0.
- FSM states:
  - IDLE: accepts commands.
  - SHIFT: one step per clk edge.
  - DONE: one cycle, done=1; then returns to IDLE.
- IDLE with load=1: q ← load_val. start is ignored that cycle; load has priority.
- IDLE with start=1, load=0, and mode ≤4: latch mode and amount.
  - amount=0: go to DONE; q is unchanged.
  - amount>0: counter ← amount; go to SHIFT.
- IDLE with start=1 and mode 5–7: ignored. No busy, no done.
- SHIFT, each edge: q ← step(q); serial_out ← the bit that left; counter decrements. When counter==1, go to DONE.
- Step definitions, applied to the latched mode:
  - LSL: q ← {q[W-2:0], serial_in}; out = q[W-1].
  - LSR: q ← {serial_in, q[W-1:1]}; out = q[0].
  - ASR: q ← {q[W-1], q[W-1:1]}; out = q[0].
  - ROL: q ← {q[W-2:0], q[W-1]}; out = q[W-1].
  - ROR: q ← {q[0], q[W-1:1]}; out = q[0].
- serial_in is sampled live on every SHIFT edge, not latched at start.
- amount > WIDTH is legal. Logical shifts saturate to all-fill; rotates wrap modulo WIDTH naturally.
- load and start during SHIFT or DONE are ignored and not queued.
- mode and amount changes after acceptance have no effect.
- busy = (state==SHIFT). done = (state==DONE).

## Timing
- Start sampled at edge E0. busy is high from E0 to E_N, where N = amount.
- q holds its final value after E_N. done is high for the cycle between E_N and E_N+1.
- amount=0: done is high in the cycle after E0; busy never asserts.
- Next command is accepted at the edge ending the DONE cycle. The earliest back-to-back start is sampled at E_N+1.
- Load latency is one edge. q updates at the edge sampling load=1.
- reset_n low at any time, including mid-SHIFT: all outputs go to their reset values immediately, without waiting for clk. The partial command is discarded.
- Release of reset_n is synchronised externally by the system; no internal synchroniser.

## Structure
- shifter_pkg holds:
  - mode constants: MODE_LSL=0, MODE_LSR=1, MODE_ASR=2, MODE_ROL=3, MODE_ROR=4;
  - FSM state encoding: IDLE, SHIFT, DONE;
  - a function that validates mode.
- One natural sub-module, shift_step: purely combinational, parametrised by WIDTH. Inputs: q, mode, serial_in. Outputs: next q, out bit.
- The top level contains the FSM, the counter, and the registers. Estimated size is ~150–250 lines total.

## Test plan
- Load and LSL: load 8'hA5, then start LSL amount=3 with serial_in=1.
  - Required: q=8'h2F, serial_out=1.
  - Required: busy high exactly 3 cycles, done one pulse in the following cycle.
- ASR: load 8'h90, start ASR amount=2 → q=8'hE4, serial_out=0.
- ROR wrap: load 8'h81, start ROR amount=9 → q=8'hC0, serial_out=1. Repeat with ROL amount=8 → q unchanged.
- Zero and reserved commands:
  - amount=0: done pulses the cycle after start, busy never high, q unchanged.
  - mode=6 with start=1: no busy, no done, q unchanged.
- Ignored requests: during SHIFT of amount=5, assert load with 8'hFF and start.
  - Required: both ignored; the result equals the uninterrupted command; done fires once.
  - Simultaneous load+start in IDLE: load taken, no shift.
- Reset mid-operation: pull reset_n low between clock edges mid-SHIFT.
  - Required: q, serial_out, busy, and done all go to 0 before the next edge.
  - After release, a new command executes correctly.
